pixel_plane_shifter: RTL and testbench
======================================

Name: pixel_plane_shifter

Overview:
- Parametrised, multi-plane successor to the 4-bit mode-select pixel shifter used in the tile/sprite pixel paths.
- Holds PLANES independent WIDTH-bit shift registers, one per bitplane. All planes share one mode select: parallel load, shift right, shift left or hold.
- Outputs one PLANES-bit pixel per shift from either end of the registers.
- Adds serial fill input, clock enable, a remaining-bits counter and a one-cycle reload request so the fetch logic can refill the shifter without gaps.

Parameters:
- WIDTH, 8, bits per plane (minimum 1).
- PLANES, 4, number of bitplanes.
- LOAD_REV, 1, 1 = parallel load is bit-reversed (DIN bit i goes to register bit WIDTH-1-i), matching the legacy shifter; 0 = straight load.
- CW, $clog2(WIDTH+1), derived width of CNT.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous reset, active-high.
- CE  in  1  pixel clock enable; when 0 all state holds.
- SEL  in  2  mode: 00 load, 01 shift right, 10 shift left, 11 hold.
- DIN  in  PLANES*WIDTH  parallel load data; plane p = DIN[p*WIDTH +: WIDTH].
- SIN  in  PLANES  serial fill bit per plane, shifted in at the vacated end.
- DOUT  out  PLANES*WIDTH  register contents, same packing as DIN.
- PIX_R  out  PLANES  bit 0 of each plane (pixel for right-shift mode).
- PIX_L  out  PLANES  bit WIDTH-1 of each plane (pixel for left-shift mode).
- CNT  out  CW  valid bits remaining since the last load.
- EMPTY  out  1  CNT == 0 (combinational from CNT).
- LOAD_REQ  out  1  registered one-cycle pulse: the last valid bit has just been shifted out.

Behaviour:
- Reset (RESET=1 at a clock edge, regardless of CE or SEL):
  - all plane registers 0, CNT 0, LOAD_REQ 0.
  - hence EMPTY=1, PIX_R=0, PIX_L=0.
  - Reset mid-operation discards contents; the counter restarts from 0.
- CE=0:
  - registers and CNT hold.
  - LOAD_REQ is driven 0 on the next edge; a pulse never extends across a disabled cycle.
- CE=1, SEL=00 (load):
  - plane p reg <= DIN slice, bit-reversed if LOAD_REV=1.
  - CNT <= WIDTH; LOAD_REQ <= 0.
- CE=1, SEL=01 (shift right):
  - reg <= {SIN[p], reg[WIDTH-1:1]}.
  - CNT <= CNT-1, saturating at 0.
- CE=1, SEL=10 (shift left):
  - reg <= {reg[WIDTH-2:0], SIN[p]}.
  - CNT decrements as for shift right.
- CE=1, SEL=11 (hold): no change; LOAD_REQ <= 0.
- WIDTH=1: both shift modes give reg <= SIN[p].
- LOAD_REQ <= 1 only on a CE=1 shift with CNT==1 (transition 1->0); otherwise LOAD_REQ <= 0.
- Shifting while CNT==0: data still shifts and fills from SIN; CNT stays 0; no LOAD_REQ.
- Latency:
  - DOUT, PIX_R, PIX_L and CNT reflect an operation one cycle after the qualifying edge.
  - LOAD_REQ is asserted in the cycle after the edge that empties the shifter. Fetch logic that loads in that cycle with CE=1 gives gapless output.
- Load, shift and hold are mutually exclusive via SEL; there is no priority case except RESET over everything.
- Legacy equivalence: PLANES=1, WIDTH=4, LOAD_REV=1, SIN=0 reproduces the legacy 4-bit shifter's DOUT sequence bit-exactly for all SEL codes.
- No combinational path from inputs to outputs except EMPTY from CNT.

Test Plan:
- Reset: hold RESET=1 with CE=1, SEL=00, DIN all ones -> after edge DOUT=0, CNT=0, EMPTY=1, LOAD_REQ=0.
- Load/reverse (defaults): DIN plane0=0x01, plane3=0xC0 -> plane0 reg=0x80, plane3 reg=0x03, CNT=8, EMPTY=0; with LOAD_REV=0 -> plane0=0x01, plane3=0xC0.
- Shift right drain: after the 0x01-reversed load, SIN=0, SEL=01 for 8 CE cycles:
  - PIX_R[0] sequence 0,0,0,0,0,0,0,1.
  - CNT 7..0.
  - LOAD_REQ high exactly the one cycle after the 8th shift; a 9th shift keeps CNT=0 with no pulse.
- Shift left with fill: load plane1 to reg 0x81, SEL=10, SIN[1]=1, 3 shifts -> reg 0x0F, PIX_L[1] sequence 1,0,0; CNT=5.
- CE gating and hold: CE toggled 1,0,1 with SEL=01, and SEL=11 with CE=1 -> only CE=1 shifts advance CNT; hold leaves DOUT/CNT unchanged; LOAD_REQ never wider than one cycle.
- Gapless reload and legacy equivalence:
  - Reload in the LOAD_REQ cycle -> PIX_R stream continuous with no repeated or skipped pixel.
  - PLANES=1, WIDTH=4 instance compared against the legacy shifter model over 1000 random SEL/DIN cycles -> identical DOUT.

Source files
------------

// File: rtl/pixel_plane_shifter.sv
// Multi-plane pixel shifter: PLANES parallel WIDTH-bit shift registers sharing one mode select,
// with serial fill, clock enable, a remaining-bits counter and a one-cycle reload request.

module pixel_plane_lane #(
  parameter int WIDTH    = 8,
  parameter bit LOAD_REV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             do_load,
  input  logic             do_shr,
  input  logic             do_shl,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] ld_val, shr_val, shl_val;

  // Reversed load puts DIN bit 0 at the left end, as the legacy shifter did.
  always_comb begin
    ld_val = din;
    if (LOAD_REV)
      for (int i = 0; i < WIDTH; i++) ld_val[i] = din[WIDTH-1-i];
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign shr_val = sin;
      assign shl_val = sin;
    end else begin : g_wn
      assign shr_val = {sin, q[WIDTH-1:1]};
      assign shl_val = {q[WIDTH-2:0], sin};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)        q <= '0;
    else if (do_load) q <= ld_val;
    else if (do_shr)  q <= shr_val;
    else if (do_shl)  q <= shl_val;
  end
endmodule

module pixel_plane_shifter #(
  parameter int WIDTH    = 8,
  parameter int PLANES   = 4,
  parameter bit LOAD_REV = 1'b1,
  parameter int CW       = $clog2(WIDTH+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic [1:0]              sel,
  input  logic [PLANES*WIDTH-1:0] din,
  input  logic [PLANES-1:0]       sin,
  output logic [PLANES*WIDTH-1:0] dout,
  output logic [PLANES-1:0]       pix_r,
  output logic [PLANES-1:0]       pix_l,
  output logic [CW-1:0]           cnt,
  output logic                    empty,
  output logic                    load_req
);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [PLANES-1:0][WIDTH-1:0] din_a, q_a;
  logic do_load, do_shr, do_shl, do_shift;

  assign din_a = din;
  assign dout  = q_a;

  always_comb begin
    do_load = 1'b0;
    do_shr  = 1'b0;
    do_shl  = 1'b0;
    if (ce) begin
      unique case (sel)
        2'b00:   do_load = 1'b1;
        2'b01:   do_shr  = 1'b1;
        2'b10:   do_shl  = 1'b1;
        default: ;
      endcase
    end
  end

  assign do_shift = do_shr | do_shl;

  genvar p;
  generate
    for (p = 0; p < PLANES; p++) begin : g_lane
      pixel_plane_lane #(
        .WIDTH    (WIDTH),
        .LOAD_REV (LOAD_REV)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .do_load (do_load),
        .do_shr  (do_shr),
        .do_shl  (do_shl),
        .din     (din_a[p]),
        .sin     (sin[p]),
        .q       (q_a[p])
      );
      assign pix_r[p] = q_a[p][0];
      assign pix_l[p] = q_a[p][WIDTH-1];
    end
  endgenerate

  // Counter saturates at 0; load_req fires only on the 1->0 transition, never while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      load_req <= 1'b0;
    end else begin
      load_req <= do_shift && (cnt == ONE);
      if (do_load)                   cnt <= FULL;
      else if (do_shift && cnt != '0) cnt <= cnt - ONE;
    end
  end

  assign empty = (cnt == '0);
endmodule

// File: tb/tb_pixel_plane_shifter.sv
// Randomized + directed bench for pixel_plane_shifter against a behavioural plane/counter model.
module tb_pixel_plane_shifter;
  localparam int W  = 8;
  localparam int P  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, ce;
  logic [1:0]       sel;
  logic [P*W-1:0]   din;
  logic [P-1:0]     sin;
  logic [P*W-1:0]   dout, dout_n;
  logic [P-1:0]     pix_r, pix_l, pix_r_n, pix_l_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             empty, lr, empty_n, lr_n;

  logic             ce_l;
  logic [1:0]       sel_l;
  logic [3:0]       din_l, dout_l;
  logic             sin_l, pix_r_l, pix_l_l, empty_l, lr_l;
  logic [2:0]       cnt_l;

  pixel_plane_shifter #(.WIDTH(W), .PLANES(P), .LOAD_REV(1'b1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .sel(sel), .din(din), .sin(sin),
    .dout(dout), .pix_r(pix_r), .pix_l(pix_l), .cnt(cnt), .empty(empty), .load_req(lr));

  pixel_plane_shifter #(.WIDTH(W), .PLANES(P), .LOAD_REV(1'b0)) dut_n (
    .clk(clk), .reset(reset), .ce(ce), .sel(sel), .din(din), .sin(sin),
    .dout(dout_n), .pix_r(pix_r_n), .pix_l(pix_l_n), .cnt(cnt_n), .empty(empty_n), .load_req(lr_n));

  pixel_plane_shifter #(.WIDTH(4), .PLANES(1), .LOAD_REV(1'b1)) dut_l (
    .clk(clk), .reset(reset), .ce(ce_l), .sel(sel_l), .din(din_l), .sin(sin_l),
    .dout(dout_l), .pix_r(pix_r_l), .pix_l(pix_l_l), .cnt(cnt_l), .empty(empty_l), .load_req(lr_l));

  logic [W-1:0] m_reg [P];
  logic [W-1:0] n_reg [P];
  int           m_cnt;
  bit           m_lr;
  logic [3:0]   m_lg;
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Model of one clock edge, written from the mode rules with plain shifts.
  task automatic model_edge();
    if (reset) m_lg = '0;
    else begin
      case (sel_l)
        2'b00:   m_lg = {din_l[0], din_l[1], din_l[2], din_l[3]};
        2'b01:   m_lg = m_lg >> 1;
        2'b10:   m_lg = m_lg << 1;
        default: ;
      endcase
    end
    if (reset) begin
      for (int p = 0; p < P; p++) begin m_reg[p] = '0; n_reg[p] = '0; end
      m_cnt = 0; m_lr = 0;
    end else if (!ce) m_lr = 0;
    else begin
      case (sel)
        2'b00: begin
          for (int p = 0; p < P; p++) begin
            n_reg[p] = din[p*W +: W];
            m_reg[p] = rev(din[p*W +: W]);
          end
          m_cnt = W; m_lr = 0;
        end
        2'b01, 2'b10: begin
          for (int p = 0; p < P; p++) begin
            if (sel == 2'b01) begin
              m_reg[p] = (m_reg[p] >> 1) | (W'(sin[p]) << (W-1));
              n_reg[p] = (n_reg[p] >> 1) | (W'(sin[p]) << (W-1));
            end else begin
              m_reg[p] = (m_reg[p] << 1) | W'(sin[p]);
              n_reg[p] = (n_reg[p] << 1) | W'(sin[p]);
            end
          end
          m_lr = (m_cnt == 1);
          if (m_cnt > 0) m_cnt--;
        end
        default: m_lr = 0;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [P*W-1:0] ed, en;
    logic [P-1:0]   er, el, nr, nl;
    for (int p = 0; p < P; p++) begin
      ed[p*W +: W] = m_reg[p];
      en[p*W +: W] = n_reg[p];
      er[p] = m_reg[p][0];   el[p] = m_reg[p][W-1];
      nr[p] = n_reg[p][0];   nl[p] = n_reg[p][W-1];
    end
    chk({tag, ".dout"},   dout,   ed);
    chk({tag, ".pix_r"},  pix_r,  er);
    chk({tag, ".pix_l"},  pix_l,  el);
    chk({tag, ".cnt"},    cnt,    m_cnt);
    chk({tag, ".empty"},  empty,  (m_cnt == 0));
    chk({tag, ".lr"},     lr,     m_lr);
    chk({tag, ".n_dout"}, dout_n, en);
    chk({tag, ".n_pix"},  {pix_r_n, pix_l_n}, {nr, nl});
    chk({tag, ".n_lr"},   lr_n,   m_lr);
    chk({tag, ".legacy"}, dout_l, m_lg);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    logic [7:0]  seq;
    logic [15:0] stream;
    logic [7:0]  a, b;
    logic [P*W-1:0] saved;

    ce_l = 1'b1; sin_l = 1'b0; sel_l = 2'b00; din_l = 4'hF;
    reset = 1'b1; ce = 1'b1; sel = 2'b00; din = '1; sin = '0;
    step("reset");
    chk("reset.dout0", dout, 0);
    chk("reset.empty1", empty, 1);

    reset = 1'b0; din = '0; din[7:0] = 8'h01; din[31:24] = 8'hC0; din_l = 4'b0001;
    step("load");
    chk("load.p0", dout[7:0], 8'h80);
    chk("load.p3", dout[31:24], 8'h03);
    chk("load.cnt8", cnt, 8);
    chk("load.nr_p0", dout_n[7:0], 8'h01);
    chk("load.nr_p3", dout_n[31:24], 8'hC0);

    sel = 2'b01; sin = '0; sel_l = 2'b01;
    for (int i = 0; i < 8; i++) begin
      seq[i] = pix_r[0];
      step("drain");
      chk("drain.cnt", cnt, 7 - i);
    end
    chk("drain.seq", seq, 8'b1000_0000);
    chk("drain.lr1", lr, 1);
    step("shift9");
    chk("shift9.cnt0", cnt, 0);
    chk("shift9.lr0", lr, 0);

    sel = 2'b00; din = '0; din[15:8] = 8'h81; sel_l = 2'b10;
    step("load81");
    sel = 2'b10; sin = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      seq[i] = pix_l[1];
      step("shl");
    end
    chk("shl.reg", dout[15:8], 8'h0F);
    chk("shl.pix_seq", seq[2:0], 3'b001);
    chk("shl.cnt5", cnt, 5);

    sel = 2'b01; sin = '0;
    ce = 1'b1; step("ce1");  chk("ce1.cnt", cnt, 4);
    ce = 1'b0; step("ce0");  chk("ce0.cnt", cnt, 4);
    ce = 1'b1; step("ce1b"); chk("ce1b.cnt", cnt, 3);
    saved = dout; sel = 2'b11;
    step("hold");
    chk("hold.dout", dout, saved);
    chk("hold.cnt", cnt, 3);
    sel = 2'b01;
    step("d2"); step("d1"); step("d0");
    chk("edge.lr1", lr, 1);
    ce = 1'b0;
    step("gate_lr");
    chk("gate_lr.lr0", lr, 0);

    // Gapless: reload during the load_req cycle; pixel stream must be A then B, MSB first.
    ce = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    din = '0; din[7:0] = a; sel = 2'b00;
    step("gl_loadA");
    stream = '0;
    sel = 2'b01;
    for (int i = 0; i < 8; i++) begin stream = {stream[14:0], pix_r[0]}; step("gl_a"); end
    chk("gl.lr_at_reload", lr, 1);
    din[7:0] = b; sel = 2'b00;
    step("gl_loadB");
    sel = 2'b01;
    for (int i = 0; i < 8; i++) begin stream = {stream[14:0], pix_r[0]}; step("gl_b"); end
    chk("gl.stream", stream, {a, b});

    for (int n = 0; n < 1000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      ce    = ($urandom_range(0, 3) != 0);
      sel   = 2'($urandom);
      if (m_lr && $urandom_range(0, 1) == 1) sel = 2'b00;
      din   = {$urandom, $urandom};
      sin   = 4'($urandom);
      sel_l = 2'($urandom);
      din_l = 4'($urandom);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
